// File: rtl/runway_occupancy_ctrl.sv
// Runway occupancy tracker: per-runway OCC/CLEAR timers with an in-order
// hold FIFO that retries grants aimed at runways that are still in use.
module runway_occupancy_ctrl #(
    parameter int DWELL = 8,
    parameter int CLEAR = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] signal,
    input  logic [1:0] d,
    output logic [3:0] busy,
    output logic [3:0] vacate,
    output logic [7:0] occ_dir,
    output logic [2:0] hold_count,
    output logic       conflict,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OCC   = 2'd1,
        ST_CLEAR = 2'd2
    } rwy_state_t;

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL - 1);
    localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR - 1);

    rwy_state_t state_reg [4];
    logic [3:0] cnt_reg   [4];
    logic [3:0] busy_reg;
    logic [3:0] vacate_reg;
    logic [7:0] occ_dir_reg;

    // Hold FIFO entries are {direction, runway index}
    logic [3:0] fifo_mem [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic       conflict_reg;
    logic       overflow_reg;

    logic       onehot;
    logic [1:0] new_idx;
    logic [1:0] head_idx;
    logic [1:0] head_dir;
    logic [3:0] eligible;
    logic       pop;
    logic       new_ok;
    logic       new_direct;
    logic       need_park;
    logic       push;
    logic       ovf_next;
    logic [3:0] start;
    logic [1:0] start_dir [4];

    // A runway in its vacate cycle is not yet offered to new traffic
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_elig
            assign eligible[gi] = (state_reg[gi] == ST_IDLE) && !vacate_reg[gi];
        end
    endgenerate

    always_comb begin
        onehot   = (signal != 4'd0) && ((signal & (signal - 4'd1)) == 4'd0);
        new_idx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (signal[i]) new_idx = 2'(i);
        end
        head_idx   = fifo_mem[rd_ptr_reg][1:0];
        head_dir   = fifo_mem[rd_ptr_reg][3:2];
        pop        = (count_reg != 3'd0) && eligible[head_idx];
        new_ok     = en && onehot;
        new_direct = new_ok && eligible[new_idx] && !(pop && (head_idx == new_idx));
        need_park  = new_ok && !new_direct;
        push       = need_park && ((count_reg != 3'd4) || pop);
        ovf_next   = need_park && (count_reg == 3'd4) && !pop;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_start
            assign start[gi]     = (pop && (head_idx == 2'(gi))) ||
                                   (new_direct && (new_idx == 2'(gi)));
            assign start_dir[gi] = (pop && (head_idx == 2'(gi))) ? head_dir : d;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rwy
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg[gi]            <= ST_IDLE;
                    cnt_reg[gi]              <= 4'd0;
                    busy_reg[gi]             <= 1'b0;
                    vacate_reg[gi]           <= 1'b0;
                    occ_dir_reg[2*gi+1:2*gi] <= 2'd0;
                end else begin
                    vacate_reg[gi] <= 1'b0;
                    case (state_reg[gi])
                        ST_IDLE: begin
                            if (start[gi]) begin
                                state_reg[gi]            <= ST_OCC;
                                cnt_reg[gi]              <= DWELL_LOAD;
                                busy_reg[gi]             <= 1'b1;
                                occ_dir_reg[2*gi+1:2*gi] <= start_dir[gi];
                            end
                        end
                        ST_OCC: begin
                            if (cnt_reg[gi] == 4'd0) begin
                                state_reg[gi] <= ST_CLEAR;
                                cnt_reg[gi]   <= CLEAR_LOAD;
                            end else begin
                                cnt_reg[gi] <= cnt_reg[gi] - 4'd1;
                            end
                        end
                        ST_CLEAR: begin
                            if (cnt_reg[gi] == 4'd0) begin
                                state_reg[gi]  <= ST_IDLE;
                                busy_reg[gi]   <= 1'b0;
                                vacate_reg[gi] <= 1'b1;
                            end else begin
                                cnt_reg[gi] <= cnt_reg[gi] - 4'd1;
                            end
                        end
                        default: begin
                            state_reg[gi] <= ST_IDLE;
                            busy_reg[gi]  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {d, new_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            count_reg    <= 3'd0;
            conflict_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            conflict_reg <= en && !onehot;
            overflow_reg <= ovf_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign vacate     = vacate_reg;
    assign occ_dir    = occ_dir_reg;
    assign hold_count = count_reg;
    assign conflict   = conflict_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_runway_occupancy_ctrl.sv
// Directed bench for runway_occupancy_ctrl; cycle n is the interval after
// grant-edge n-1 of the current scenario (cyc counts edges since its start).
module tb_runway_occupancy_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] signal;
    logic [1:0] d;
    logic [3:0] busy;
    logic [3:0] vacate;
    logic [7:0] occ_dir;
    logic [2:0] hold_count;
    logic       conflict;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    runway_occupancy_ctrl #(.DWELL(8), .CLEAR(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .signal     (signal),
        .d          (d),
        .busy       (busy),
        .vacate     (vacate),
        .occ_dir    (occ_dir),
        .hold_count (hold_count),
        .conflict   (conflict),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cyc %0d)", tag, got, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic grant(input logic [3:0] s, input logic [1:0] dd);
        en = 1'b1; signal = s; d = dd;
        tick();
        en = 1'b0; signal = 4'd0; d = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic seen_bad;
        rst = 1'b1; en = 1'b0; signal = 4'd0; d = 2'd0;
        do_reset();
        chk("reset_busy",     32'(busy), 0);
        chk("reset_vacate",   32'(vacate), 0);
        chk("reset_occdir",   32'(occ_dir), 0);
        chk("reset_hold",     32'(hold_count), 0);
        chk("reset_conflict", 32'(conflict), 0);
        chk("reset_overflow", 32'(overflow), 0);

        // Single grant: busy cycles 1..10, vacate at 11
        grant(4'b0001, 2'd2);
        chk("single_dir", 32'(occ_dir[1:0]), 2);
        seen_bad = 1'b0;
        while (cyc <= 10) begin
            if (busy !== 4'b0001 || vacate !== 4'b0000) seen_bad = 1'b1;
            tick();
        end
        chk("single_busy_1_10", 32'(seen_bad), 0);
        chk("single_busy_11",   32'(busy), 0);
        chk("single_vacate_11", 32'(vacate), 4'b0001);
        tick();
        chk("single_vacate_12", 32'(vacate), 0);
        chk("single_dir_hold",  32'(occ_dir[1:0]), 2);

        // Park and retry
        do_reset();
        grant(4'b0001, 2'd0);
        tick();
        grant(4'b0001, 2'd3);
        chk("park_hold_3", 32'(hold_count), 1);
        wait_cyc(11);
        chk("park_vacate_11", 32'(vacate), 4'b0001);
        chk("park_hold_11",   32'(hold_count), 1);
        tick();
        chk("park_busy_12",   32'(busy), 0);
        tick();
        chk("park_busy_13",   32'(busy), 4'b0001);
        chk("park_dir_13",    32'(occ_dir[1:0]), 3);
        chk("park_hold_13",   32'(hold_count), 0);

        // Overflow
        do_reset();
        grant(4'b0100, 2'd1);
        for (int k = 1; k <= 5; k++) begin
            grant(4'b0100, 2'(k));
            if (k <= 4) chk($sformatf("ovf_hold_%0d", k), 32'(hold_count), 32'(k));
            chk($sformatf("ovf_pulse_%0d", k), 32'(overflow), (k == 5) ? 1 : 0);
        end
        chk("ovf_hold_full", 32'(hold_count), 4);
        tick();
        chk("ovf_pulse_clear", 32'(overflow), 0);
        chk("ovf_hold_stay",   32'(hold_count), 4);
        chk("ovf_dir_first",   32'(occ_dir[5:4]), 1);

        // Conflict
        do_reset();
        grant(4'b0101, 2'd1);
        chk("conf_multi", 32'(conflict), 1);
        grant(4'b0000, 2'd2);
        chk("conf_zero",  32'(conflict), 1);
        tick();
        chk("conf_clear", 32'(conflict), 0);
        chk("conf_busy",  32'(busy), 0);
        chk("conf_hold",  32'(hold_count), 0);

        // Simultaneous: head retry to r1 and new grant to r3
        do_reset();
        grant(4'b0010, 2'd0);
        grant(4'b0010, 2'd1);
        wait_cyc(12);
        grant(4'b1000, 2'd2);
        chk("sim_busy",   32'(busy), 4'b1010);
        chk("sim_hold",   32'(hold_count), 0);
        chk("sim_dir_r1", 32'(occ_dir[3:2]), 1);
        chk("sim_dir_r3", 32'(occ_dir[7:6]), 2);

        // Same runway: head wins, new grant is parked and later retried
        do_reset();
        grant(4'b0010, 2'd0);
        grant(4'b0010, 2'd1);
        wait_cyc(12);
        grant(4'b0010, 2'd2);
        chk("same_busy", 32'(busy), 4'b0010);
        chk("same_hold", 32'(hold_count), 1);
        chk("same_dir",  32'(occ_dir[3:2]), 1);
        wait_cyc(23);
        chk("same_vacate_23", 32'(vacate), 4'b0010);
        wait_cyc(25);
        chk("same_busy_25", 32'(busy), 4'b0010);
        chk("same_dir_25",  32'(occ_dir[3:2]), 2);
        chk("same_hold_25", 32'(hold_count), 0);

        // Reset mid-dwell flushes runways and FIFO, no vacate afterwards
        do_reset();
        grant(4'b0001, 2'd3);
        grant(4'b0001, 2'd1);
        grant(4'b0001, 2'd2);
        chk("rst_hold_pre", 32'(hold_count), 2);
        wait_cyc(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy",   32'(busy), 0);
        chk("rst_hold",   32'(hold_count), 0);
        chk("rst_occdir", 32'(occ_dir), 0);
        chk("rst_vacate", 32'(vacate), 0);
        seen_bad = 1'b0;
        while (cyc < 30) begin
            tick();
            if (vacate !== 4'b0000 || busy !== 4'b0000) seen_bad = 1'b1;
        end
        chk("rst_no_vacate", 32'(seen_bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

endmodule
